// File: rtl/psum_accumulator_pkg.sv
// Shared types and helpers for the partial-sum accumulator: FSM states,
// lane count per column and the packed psum bus lane addressing.
package psum_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int LANES = 4;

    // Bit offset of lane `lane` of column `col` inside the packed psum row (lane 0 = LSBs).
    function automatic int lane_lsb(input int col, input int lane, input int col_width);
        return (col * LANES + lane) * col_width;
    endfunction

endpackage

// File: rtl/psum_accumulator_if.sv
// Drain stream from the accumulator to the output buffer: one column per
// valid/ready beat, carrying all lanes of that column.
interface psum_accumulator_if
    import psum_acc_pkg::*;
#(
    parameter int LOG_ARRAY_SIZE = 3,
    parameter int ACC_WIDTH      = 32
);

    logic                        out_valid;
    logic                        out_ready;
    logic [LOG_ARRAY_SIZE-1:0]   out_col;
    logic [LANES*ACC_WIDTH-1:0]  out_data;
    logic                        out_last;

    modport master (
        output out_valid,
        output out_col,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_col,
        input  out_data,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/psum_accumulator_lane.sv
// One signed accumulator lane: sign-extends the incoming psum, adds with
// wrap-around and flags a signed overflow on the add being committed.
module psum_lane_acc #(
    parameter int IN_W  = 13,
    parameter int ACC_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   en,
    input  logic signed [IN_W-1:0] din,
    output logic [ACC_W-1:0]       acc,
    output logic                   ovf
);

    logic [ACC_W-1:0] addend;
    logic [ACC_W-1:0] sum;

    assign addend = ACC_W'($signed(din));
    assign sum    = acc + addend;

    // Overflow: both operands share a sign that the wrapped result does not.
    assign ovf = en && (acc[ACC_W-1] == addend[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates the systolic array's last-row partial sums over a programmed
// number of passes, then drains one column per beat over a valid/ready stream.
module psum_accumulator
    import psum_acc_pkg::*;
#(
    parameter int ARRAY_SIZE     = 8,
    parameter int LOG_ARRAY_SIZE = 3,
    parameter int COL_WIDTH      = 10 + LOG_ARRAY_SIZE,
    parameter int ACC_WIDTH      = 32,
    parameter int PASS_W         = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [PASS_W-1:0]                    num_passes,
    output logic                                 busy,
    input  logic                                 psum_valid,
    input  logic [ARRAY_SIZE*LANES*COL_WIDTH-1:0] psums,
    output logic                                 overflow,
    psum_accumulator_if.master                   drain
);

    state_t                      state;
    logic [PASS_W-1:0]           passes;
    logic [PASS_W-1:0]           pass_cnt;
    logic [LOG_ARRAY_SIZE-1:0]   col;
    logic                        job_accept;
    logic                        row_accept;
    logic                        last_pass;
    logic                        last_col;
    logic [ARRAY_SIZE*LANES-1:0] lane_ovf;
    logic [ACC_WIDTH-1:0]        acc_q [ARRAY_SIZE][LANES];
    logic [LANES*ACC_WIDTH-1:0]  col_data;

    assign job_accept = (state == IDLE) && start && (num_passes != '0);
    assign row_accept = (state == ACCUM) && psum_valid;
    assign last_pass  = (pass_cnt == passes - PASS_W'(1));
    assign last_col   = (col == LOG_ARRAY_SIZE'(ARRAY_SIZE - 1));

    for (genvar c = 0; c < ARRAY_SIZE; c++) begin : g_col
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            localparam int LSB = lane_lsb(c, l, COL_WIDTH);

            psum_lane_acc #(
                .IN_W  (COL_WIDTH),
                .ACC_W (ACC_WIDTH)
            ) u_lane (
                .clk   (clk),
                .rst_n (rst_n),
                .clear (job_accept),
                .en    (row_accept),
                .din   (psums[LSB +: COL_WIDTH]),
                .acc   (acc_q[c][l]),
                .ovf   (lane_ovf[c*LANES + l])
            );
        end
    end

    // Output data is a pure mux of accumulator registers by the registered column.
    always_comb begin
        col_data = '0;
        for (int l = 0; l < LANES; l++) begin
            col_data[l*ACC_WIDTH +: ACC_WIDTH] = acc_q[col][l];
        end
    end

    assign drain.out_data = col_data;
    assign drain.out_col  = col;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            passes          <= '0;
            pass_cnt        <= '0;
            col             <= '0;
            busy            <= 1'b0;
            overflow        <= 1'b0;
            drain.out_valid <= 1'b0;
            drain.out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (job_accept) begin
                        passes   <= num_passes;
                        pass_cnt <= '0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (psum_valid) begin
                        pass_cnt <= pass_cnt + PASS_W'(1);
                        if (|lane_ovf) begin
                            overflow <= 1'b1;
                        end
                        if (last_pass) begin
                            state           <= DRAIN;
                            col             <= '0;
                            drain.out_valid <= 1'b1;
                            drain.out_last  <= (ARRAY_SIZE == 1);
                        end
                    end
                end
                DRAIN: begin
                    // Column, data and last stay frozen until the consumer takes the beat.
                    if (drain.out_ready) begin
                        if (last_col) begin
                            state           <= IDLE;
                            col             <= '0;
                            busy            <= 1'b0;
                            drain.out_valid <= 1'b0;
                            drain.out_last  <= 1'b0;
                        end else begin
                            col            <= col + LOG_ARRAY_SIZE'(1);
                            drain.out_last <= (col == LOG_ARRAY_SIZE'(ARRAY_SIZE - 2));
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// Randomized bench for psum_accumulator: a wide (32-bit) and a narrow
// (COL_WIDTH+1) instance share stimulus and are checked against an arithmetic model.
module tb_psum_accumulator;
    import psum_acc_pkg::*;

    localparam int AS   = 8;
    localparam int LAS  = 3;
    localparam int CW   = 10 + LAS;
    localparam int PW   = 8;
    localparam int AW_W = 32;
    localparam int AW_N = CW + 1;

    localparam int K_CONST = 0;
    localparam int K_COLP1 = 1;
    localparam int K_SMALL = 2;
    localparam int K_FULL  = 3;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    start = 1'b0;
    logic [PW-1:0]           num_passes = '0;
    logic                    psum_valid = 1'b0;
    logic [AS*LANES*CW-1:0]  psums = '0;
    logic                    out_ready = 1'b1;
    logic                    busy_w, busy_n, ovf_w, ovf_n;

    int n_compared = 0;
    int n_failed   = 0;
    bit cmp_en     = 1'b0;
    int ready_mode = 0;
    int ready_cnt  = 0;

    // Behavioural model state
    bit     m_busy, m_drain, m_ovf_w, m_ovf_n;
    int     rows_left, beat;
    longint acc_w [AS][LANES];
    longint acc_n [AS][LANES];

    // Beats captured at each handshake
    int     q_col[$];
    bit     q_last[$];
    longint q_w[$];
    longint q_n[$];

    psum_accumulator_if #(.LOG_ARRAY_SIZE(LAS), .ACC_WIDTH(AW_W)) drain_w ();
    psum_accumulator_if #(.LOG_ARRAY_SIZE(LAS), .ACC_WIDTH(AW_N)) drain_n ();

    assign drain_w.out_ready = out_ready;
    assign drain_n.out_ready = out_ready;

    psum_accumulator #(
        .ARRAY_SIZE(AS), .LOG_ARRAY_SIZE(LAS), .COL_WIDTH(CW), .ACC_WIDTH(AW_W), .PASS_W(PW)
    ) dut_w (
        .clk(clk), .rst_n(rst_n), .start(start), .num_passes(num_passes), .busy(busy_w),
        .psum_valid(psum_valid), .psums(psums), .overflow(ovf_w), .drain(drain_w)
    );

    psum_accumulator #(
        .ARRAY_SIZE(AS), .LOG_ARRAY_SIZE(LAS), .COL_WIDTH(CW), .ACC_WIDTH(AW_N), .PASS_W(PW)
    ) dut_n (
        .clk(clk), .rst_n(rst_n), .start(start), .num_passes(num_passes), .busy(busy_n),
        .psum_valid(psum_valid), .psums(psums), .overflow(ovf_n), .drain(drain_n)
    );

    always #5 clk = ~clk;

    function automatic longint wrap(input longint v, input int w);
        longint span;
        longint r;
        span = longint'(1) <<< w;
        r = v % span;
        if (r >= span / 2) r = r - span;
        else if (r < -(span / 2)) r = r + span;
        return r;
    endfunction

    task automatic check_output(input string name, input longint act, input longint exp);
        n_compared++;
        if (act != exp) begin
            n_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: whole-row additions with exact arithmetic, wrapped to each width afterwards.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_drain = 0; m_ovf_w = 0; m_ovf_n = 0; rows_left = 0; beat = 0;
            for (int c = 0; c < AS; c++)
                for (int l = 0; l < LANES; l++) begin
                    acc_w[c][l] = 0; acc_n[c][l] = 0;
                end
        end else if (!m_busy) begin
            if (start && num_passes != 0) begin
                m_busy = 1; m_drain = 0; m_ovf_w = 0; m_ovf_n = 0; rows_left = int'(num_passes);
                for (int c = 0; c < AS; c++)
                    for (int l = 0; l < LANES; l++) begin
                        acc_w[c][l] = 0; acc_n[c][l] = 0;
                    end
            end
        end else if (!m_drain) begin
            if (psum_valid) begin
                for (int c = 0; c < AS; c++)
                    for (int l = 0; l < LANES; l++) begin
                        longint x, ew, en;
                        x  = longint'($signed(psums[(c*LANES + l)*CW +: CW]));
                        ew = acc_w[c][l] + x;
                        en = acc_n[c][l] + x;
                        if (wrap(ew, AW_W) != ew) m_ovf_w = 1;
                        if (wrap(en, AW_N) != en) m_ovf_n = 1;
                        acc_w[c][l] = wrap(ew, AW_W);
                        acc_n[c][l] = wrap(en, AW_N);
                    end
                rows_left--;
                if (rows_left == 0) begin
                    m_drain = 1; beat = 0;
                end
            end
        end else if (out_ready) begin
            if (beat == AS - 1) begin
                m_busy = 0; m_drain = 0; beat = 0;
            end else begin
                beat++;
            end
        end
    end

    // Compare process: every output of both instances on every cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            check_output("busy_w", longint'(busy_w), longint'(m_busy));
            check_output("busy_n", longint'(busy_n), longint'(m_busy));
            check_output("valid_w", longint'(drain_w.out_valid), longint'(m_drain));
            check_output("valid_n", longint'(drain_n.out_valid), longint'(m_drain));
            check_output("last_w", longint'(drain_w.out_last), longint'(m_drain && beat == AS - 1));
            check_output("last_n", longint'(drain_n.out_last), longint'(m_drain && beat == AS - 1));
            check_output("ovf_w", longint'(ovf_w), longint'(m_ovf_w));
            check_output("ovf_n", longint'(ovf_n), longint'(m_ovf_n));
            if (m_drain) begin
                check_output("col_w", longint'(drain_w.out_col), longint'(beat));
                check_output("col_n", longint'(drain_n.out_col), longint'(beat));
                for (int l = 0; l < LANES; l++) begin
                    check_output("data_w", longint'($signed(drain_w.out_data[l*AW_W +: AW_W])), acc_w[beat][l]);
                    check_output("data_n", longint'($signed(drain_n.out_data[l*AW_N +: AW_N])), acc_n[beat][l]);
                end
            end
        end
    end

    // Beat capture: ready is stable between this edge and the next rising edge.
    always @(negedge clk) begin
        if (rst_n && drain_w.out_valid && out_ready) begin
            q_col.push_back(int'(drain_w.out_col));
            q_last.push_back(drain_w.out_last);
            for (int l = 0; l < LANES; l++) begin
                q_w.push_back(longint'($signed(drain_w.out_data[l*AW_W +: AW_W])));
                q_n.push_back(longint'($signed(drain_n.out_data[l*AW_N +: AW_N])));
            end
        end
    end

    always @(posedge clk) begin
        #1;
        ready_cnt++;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = (ready_cnt % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_queues();
        q_col.delete(); q_last.delete(); q_w.delete(); q_n.delete();
    endtask

    task automatic fill_row(input int kind, input int val);
        for (int c = 0; c < AS; c++)
            for (int l = 0; l < LANES; l++) begin
                int v;
                case (kind)
                    K_CONST: v = val;
                    K_COLP1: v = c + 1;
                    K_SMALL: v = int'($urandom_range(0, 600)) - 300;
                    default: v = int'($urandom_range(0, 8191)) - 4096;
                endcase
                psums[(c*LANES + l)*CW +: CW] = v[CW-1:0];
            end
    endtask

    // One job: accepted start, then `passes` rows with random gaps (stray starts in gaps).
    task automatic apply_stimulus(input int passes, input int kind, input int val,
                                  input int gap_max, input bit stray);
        start = 1'b1;
        num_passes = PW'(passes);
        tick();
        start = 1'b0;
        for (int p = 0; p < passes; p++) begin
            int gap;
            gap = int'($urandom_range(0, gap_max));
            for (int g = 0; g < gap; g++) begin
                start = stray ? 1'($urandom_range(0, 1)) : 1'b0;
                num_passes = PW'($urandom_range(0, 255));
                tick();
            end
            start = 1'b0;
            fill_row(kind, val);
            psum_valid = 1'b1;
            tick();
            psum_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input bit stray);
        int n;
        n = 0;
        while (busy_w && n < 300) begin
            psum_valid = stray ? 1'($urandom_range(0, 1)) : 1'b0;
            start = stray ? 1'($urandom_range(0, 1)) : 1'b0;
            num_passes = PW'($urandom_range(1, 4));
            tick();
            n++;
        end
        psum_valid = 1'b0;
        start = 1'b0;
        check_output("idle_timeout", longint'(busy_w), 0);
    endtask

    initial begin
        int t2_vals[3];
        int n;
        t2_vals = '{5, -2, 7};

        // Reset values
        repeat (3) tick();
        check_output("rst_busy", longint'(busy_w), 0);
        check_output("rst_valid", longint'(drain_w.out_valid), 0);
        check_output("rst_col", longint'(drain_w.out_col), 0);
        check_output("rst_data", longint'(drain_w.out_data), 0);
        check_output("rst_last", longint'(drain_w.out_last), 0);
        check_output("rst_ovf", longint'(ovf_n), 0);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        tick();

        // Single pass: column c holds c+1 in every lane
        $display("[TB] single pass");
        clear_queues();
        apply_stimulus(1, K_COLP1, 0, 0, 0);
        wait_idle(0);
        check_output("t1_beats", q_col.size(), AS);
        for (int k = 0; k < q_col.size() && k < AS; k++) begin
            check_output("t1_col", q_col[k], k);
            check_output("t1_last", longint'(q_last[k]), longint'(k == AS - 1));
            for (int l = 0; l < LANES; l++) begin
                check_output("t1_lane_w", q_w[k*LANES + l], k + 1);
                check_output("t1_lane_n", q_n[k*LANES + l], k + 1);
            end
        end

        // Multi-pass with gaps, stray psum_valid in IDLE and stray starts in ACCUM
        $display("[TB] multi-pass with gaps");
        clear_queues();
        fill_row(K_FULL, 0);
        psum_valid = 1'b1;
        repeat (2) tick();
        psum_valid = 1'b0;
        start = 1'b1;
        num_passes = 8'd3;
        tick();
        for (int i = 0; i < 3; i++) begin
            repeat (2) begin
                start = 1'b1;
                num_passes = 8'd5;
                tick();
            end
            start = 1'b0;
            fill_row(K_CONST, t2_vals[i]);
            psum_valid = 1'b1;
            if (i == 2) check_output("t2_no_early_drain", longint'(drain_w.out_valid), 0);
            tick();
            psum_valid = 1'b0;
        end
        check_output("t2_drain_latency", longint'(drain_w.out_valid), 1);
        check_output("t2_model_pin", acc_w[3][2], 10);
        wait_idle(0);
        check_output("t2_beats", q_col.size(), AS);
        for (int k = 0; k < q_w.size(); k++) check_output("t2_lane", q_w[k], 10);

        // Backpressure with stray inputs during DRAIN
        $display("[TB] backpressure");
        clear_queues();
        ready_mode = 1;
        apply_stimulus(2, K_SMALL, 0, 2, 1);
        wait_idle(1);
        check_output("t3_beats", q_col.size(), AS);
        for (int k = 0; k < q_col.size(); k++) check_output("t3_order", q_col[k], k);

        // Signed overflow on the narrow instance
        $display("[TB] overflow");
        clear_queues();
        ready_mode = 0;
        apply_stimulus(3, K_CONST, 4095, 0, 0);
        wait_idle(0);
        check_output("t4_ovf_n", longint'(ovf_n), 1);
        check_output("t4_ovf_w", longint'(ovf_w), 0);
        check_output("t4_wrap_n", q_n[0], -4099);
        check_output("t4_sum_w", q_w[0], 12285);
        start = 1'b1;
        num_passes = 8'd0;
        tick();
        start = 1'b0;
        check_output("t5_zero_busy", longint'(busy_w), 0);
        check_output("t5_zero_ovf", longint'(ovf_n), 1);
        start = 1'b1;
        num_passes = 8'd1;
        tick();
        start = 1'b0;
        check_output("t5_clear_ovf", longint'(ovf_n), 0);
        check_output("t5_busy", longint'(busy_w), 1);
        fill_row(K_SMALL, 0);
        psum_valid = 1'b1;
        tick();
        psum_valid = 1'b0;
        wait_idle(0);

        // Randomized jobs
        $display("[TB] random jobs");
        for (int j = 0; j < 25; j++) begin
            ready_mode = int'($urandom_range(0, 2));
            apply_stimulus(int'($urandom_range(1, 6)), int'($urandom_range(K_SMALL, K_FULL)), 0,
                           int'($urandom_range(0, 3)), 1);
            wait_idle(1);
            repeat (int'($urandom_range(0, 2))) tick();
        end

        // Reset in the middle of DRAIN
        $display("[TB] reset mid-drain");
        ready_mode = 0;
        apply_stimulus(2, K_FULL, 0, 1, 0);
        n = 0;
        while (!(drain_w.out_valid && drain_w.out_col == 3) && n < 40) begin
            tick();
            n++;
        end
        check_output("t6_reach_col3", longint'(drain_w.out_col), 3);
        rst_n = 1'b0;
        #1;
        check_output("t6_busy", longint'(busy_w), 0);
        check_output("t6_valid", longint'(drain_w.out_valid), 0);
        check_output("t6_col", longint'(drain_w.out_col), 0);
        check_output("t6_data", longint'(drain_w.out_data), 0);
        check_output("t6_last", longint'(drain_w.out_last), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        clear_queues();
        apply_stimulus(1, K_CONST, 3, 0, 0);
        wait_idle(0);
        check_output("t6_beats", q_col.size(), AS);
        for (int k = 0; k < q_w.size(); k++) check_output("t6_fresh", q_w[k], 3);

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
